axi_lite_qos_arbiter: RTL and testbench

AXI_LITE_QOS_ARBITER -- requirements
Module: axi_lite_qos_arbiter

---
 rtl/axi_lite_qos_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_lite_qos_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_qos_arbiter.sv
// AXI4-Lite N:1 arbiter with independent write and read paths.
// Round-robin or fixed-priority selection, grant held until the response completes.
module axi_lite_qos_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 0
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [NUM_MASTERS-1:0]               i_m_axi_awvalid,
    output logic [NUM_MASTERS-1:0]               o_m_axi_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    i_m_axi_awaddr,
    input  logic [NUM_MASTERS*3-1:0]             i_m_axi_awprot,
    input  logic [NUM_MASTERS-1:0]               i_m_axi_wvalid,
    output logic [NUM_MASTERS-1:0]               o_m_axi_wready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    i_m_axi_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  i_m_axi_wstrb,
    output logic [NUM_MASTERS-1:0]               o_m_axi_bvalid,
    input  logic [NUM_MASTERS-1:0]               i_m_axi_bready,
    output logic [NUM_MASTERS*2-1:0]             o_m_axi_bresp,
    input  logic [NUM_MASTERS-1:0]               i_m_axi_arvalid,
    output logic [NUM_MASTERS-1:0]               o_m_axi_arready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    i_m_axi_araddr,
    input  logic [NUM_MASTERS*3-1:0]             i_m_axi_arprot,
    output logic [NUM_MASTERS-1:0]               o_m_axi_rvalid,
    input  logic [NUM_MASTERS-1:0]               i_m_axi_rready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]    o_m_axi_rdata,
    output logic [NUM_MASTERS*2-1:0]             o_m_axi_rresp,
    output logic                                 o_s_axi_awvalid,
    output logic [ADDR_WIDTH-1:0]                o_s_axi_awaddr,
    output logic [2:0]                           o_s_axi_awprot,
    input  logic                                 i_s_axi_awready,
    output logic                                 o_s_axi_wvalid,
    output logic [DATA_WIDTH-1:0]                o_s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]              o_s_axi_wstrb,
    input  logic                                 i_s_axi_wready,
    input  logic                                 i_s_axi_bvalid,
    input  logic [1:0]                           i_s_axi_bresp,
    output logic                                 o_s_axi_bready,
    output logic                                 o_s_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]                o_s_axi_araddr,
    output logic [2:0]                           o_s_axi_arprot,
    input  logic                                 i_s_axi_arready,
    input  logic                                 i_s_axi_rvalid,
    input  logic [DATA_WIDTH-1:0]                i_s_axi_rdata,
    input  logic [1:0]                           i_s_axi_rresp,
    output logic                                 o_s_axi_rready,
    output logic [NUM_MASTERS-1:0]               o_wr_grant,
    output logic [NUM_MASTERS-1:0]               o_rd_grant
);

    localparam int N      = NUM_MASTERS;
    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t        wr_state_q;
    rd_state_t        rd_state_q;
    logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
    logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [N-1:0]     wr_grant_q, rd_grant_q;
    logic [IDX_W-1:0] wr_win_d, rd_win_d;

    // Fixed priority scans from 0; round-robin scans upward from the pointer, wrapping.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] win;
        logic             found;
        int               j;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (ARB_MODE == 1) begin
                j = k;
            end else begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
            end
            if (req[j] && !found) begin
                win   = IDX_W'(j);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= N - 1) return '0;
        return idx + 1'b1;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign wr_win_d = pick(i_m_axi_awvalid, wr_ptr_q);
    assign rd_win_d = pick(i_m_axi_arvalid, rd_ptr_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
            wr_grant_q <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: if (|i_m_axi_awvalid) begin
                    wr_idx_q   <= wr_win_d;
                    wr_grant_q <= onehot(wr_win_d);
                    wr_state_q <= W_ADDR;
                end
                W_ADDR: if (o_s_axi_awvalid && i_s_axi_awready) wr_state_q <= W_DATA;
                W_DATA: if (o_s_axi_wvalid && i_s_axi_wready) wr_state_q <= W_RESP;
                W_RESP: if (i_s_axi_bvalid && o_s_axi_bready) begin
                    wr_state_q <= W_IDLE;
                    wr_grant_q <= '0;
                    if (ARB_MODE == 0) wr_ptr_q <= next_ptr(wr_idx_q);
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_ptr_q   <= '0;
            rd_grant_q <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (|i_m_axi_arvalid) begin
                    rd_idx_q   <= rd_win_d;
                    rd_grant_q <= onehot(rd_win_d);
                    rd_state_q <= R_ADDR;
                end
                R_ADDR: if (o_s_axi_arvalid && i_s_axi_arready) rd_state_q <= R_DATA;
                R_DATA: if (i_s_axi_rvalid && o_s_axi_rready) begin
                    rd_state_q <= R_IDLE;
                    rd_grant_q <= '0;
                    if (ARB_MODE == 0) rd_ptr_q <= next_ptr(rd_idx_q);
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Only the granted master is connected, and only during the active phase.
    always_comb begin
        o_s_axi_awvalid = 1'b0;
        o_s_axi_awaddr  = '0;
        o_s_axi_awprot  = '0;
        o_s_axi_wvalid  = 1'b0;
        o_s_axi_wdata   = '0;
        o_s_axi_wstrb   = '0;
        o_s_axi_bready  = 1'b0;
        o_m_axi_awready = '0;
        o_m_axi_wready  = '0;
        o_m_axi_bvalid  = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_idx_q == IDX_W'(i)) begin
                case (wr_state_q)
                    W_ADDR: begin
                        o_s_axi_awvalid    = i_m_axi_awvalid[i];
                        o_s_axi_awaddr     = i_m_axi_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        o_s_axi_awprot     = i_m_axi_awprot[i*3 +: 3];
                        o_m_axi_awready[i] = i_s_axi_awready;
                    end
                    W_DATA: begin
                        o_s_axi_wvalid    = i_m_axi_wvalid[i];
                        o_s_axi_wdata     = i_m_axi_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                        o_s_axi_wstrb     = i_m_axi_wstrb[i*STRB_W +: STRB_W];
                        o_m_axi_wready[i] = i_s_axi_wready;
                    end
                    W_RESP: begin
                        o_s_axi_bready    = i_m_axi_bready[i];
                        o_m_axi_bvalid[i] = i_s_axi_bvalid;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_s_axi_arvalid = 1'b0;
        o_s_axi_araddr  = '0;
        o_s_axi_arprot  = '0;
        o_s_axi_rready  = 1'b0;
        o_m_axi_arready = '0;
        o_m_axi_rvalid  = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx_q == IDX_W'(i)) begin
                case (rd_state_q)
                    R_ADDR: begin
                        o_s_axi_arvalid    = i_m_axi_arvalid[i];
                        o_s_axi_araddr     = i_m_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        o_s_axi_arprot     = i_m_axi_arprot[i*3 +: 3];
                        o_m_axi_arready[i] = i_s_axi_arready;
                    end
                    R_DATA: begin
                        o_s_axi_rready    = i_m_axi_rready[i];
                        o_m_axi_rvalid[i] = i_s_axi_rvalid;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Response payloads are broadcast; the per-master valid qualifies them.
    assign o_m_axi_bresp = {N{i_s_axi_bresp}};
    assign o_m_axi_rdata = {N{i_s_axi_rdata}};
    assign o_m_axi_rresp = {N{i_s_axi_rresp}};

    assign o_wr_grant = wr_grant_q;
    assign o_rd_grant = rd_grant_q;

endmodule

// File: tb/tb_axi_lite_qos_arbiter.sv
// Directed bench: round-robin and fixed-priority instances driven by the same masters and slave.
module tb_axi_lite_qos_arbiter;

    logic        clk;
    logic        resetn;
    logic [2:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [95:0] m_awaddr, m_wdata, m_araddr;
    logic [8:0]  m_awprot, m_arprot;
    logic [11:0] m_wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    logic [2:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid, wr_grant, rd_grant;
    logic [5:0]  m_bresp, m_rresp;
    logic [95:0] m_rdata;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;

    logic [2:0]  f_m_awready, f_m_wready, f_m_bvalid, f_m_arready, f_m_rvalid, f_wr_grant, f_rd_grant;
    logic [5:0]  f_m_bresp, f_m_rresp;
    logic [95:0] f_m_rdata;
    logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;
    logic [31:0] f_s_awaddr, f_s_wdata, f_s_araddr;
    logic [2:0]  f_s_awprot, f_s_arprot;
    logic [3:0]  f_s_wstrb;

    int checks = 0;
    int errors = 0;

    axi_lite_qos_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .i_m_axi_awvalid(m_awvalid), .o_m_axi_awready(m_awready), .i_m_axi_awaddr(m_awaddr),
        .i_m_axi_awprot(m_awprot), .i_m_axi_wvalid(m_wvalid), .o_m_axi_wready(m_wready),
        .i_m_axi_wdata(m_wdata), .i_m_axi_wstrb(m_wstrb), .o_m_axi_bvalid(m_bvalid),
        .i_m_axi_bready(m_bready), .o_m_axi_bresp(m_bresp), .i_m_axi_arvalid(m_arvalid),
        .o_m_axi_arready(m_arready), .i_m_axi_araddr(m_araddr), .i_m_axi_arprot(m_arprot),
        .o_m_axi_rvalid(m_rvalid), .i_m_axi_rready(m_rready), .o_m_axi_rdata(m_rdata),
        .o_m_axi_rresp(m_rresp),
        .o_s_axi_awvalid(s_awvalid), .o_s_axi_awaddr(s_awaddr), .o_s_axi_awprot(s_awprot),
        .i_s_axi_awready(s_awready), .o_s_axi_wvalid(s_wvalid), .o_s_axi_wdata(s_wdata),
        .o_s_axi_wstrb(s_wstrb), .i_s_axi_wready(s_wready), .i_s_axi_bvalid(s_bvalid),
        .i_s_axi_bresp(s_bresp), .o_s_axi_bready(s_bready), .o_s_axi_arvalid(s_arvalid),
        .o_s_axi_araddr(s_araddr), .o_s_axi_arprot(s_arprot), .i_s_axi_arready(s_arready),
        .i_s_axi_rvalid(s_rvalid), .i_s_axi_rdata(s_rdata), .i_s_axi_rresp(s_rresp),
        .o_s_axi_rready(s_rready), .o_wr_grant(wr_grant), .o_rd_grant(rd_grant)
    );

    axi_lite_qos_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .i_m_axi_awvalid(m_awvalid), .o_m_axi_awready(f_m_awready), .i_m_axi_awaddr(m_awaddr),
        .i_m_axi_awprot(m_awprot), .i_m_axi_wvalid(m_wvalid), .o_m_axi_wready(f_m_wready),
        .i_m_axi_wdata(m_wdata), .i_m_axi_wstrb(m_wstrb), .o_m_axi_bvalid(f_m_bvalid),
        .i_m_axi_bready(m_bready), .o_m_axi_bresp(f_m_bresp), .i_m_axi_arvalid(m_arvalid),
        .o_m_axi_arready(f_m_arready), .i_m_axi_araddr(m_araddr), .i_m_axi_arprot(m_arprot),
        .o_m_axi_rvalid(f_m_rvalid), .i_m_axi_rready(m_rready), .o_m_axi_rdata(f_m_rdata),
        .o_m_axi_rresp(f_m_rresp),
        .o_s_axi_awvalid(f_s_awvalid), .o_s_axi_awaddr(f_s_awaddr), .o_s_axi_awprot(f_s_awprot),
        .i_s_axi_awready(s_awready), .o_s_axi_wvalid(f_s_wvalid), .o_s_axi_wdata(f_s_wdata),
        .o_s_axi_wstrb(f_s_wstrb), .i_s_axi_wready(s_wready), .i_s_axi_bvalid(s_bvalid),
        .i_s_axi_bresp(s_bresp), .o_s_axi_bready(f_s_bready), .o_s_axi_arvalid(f_s_arvalid),
        .o_s_axi_araddr(f_s_araddr), .o_s_axi_arprot(f_s_arprot), .i_s_axi_arready(s_arready),
        .i_s_axi_rvalid(s_rvalid), .i_s_axi_rdata(s_rdata), .i_s_axi_rresp(s_rresp),
        .o_s_axi_rready(f_s_rready), .o_wr_grant(f_wr_grant), .o_rd_grant(f_rd_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [2:0] g);
        case (g)
            3'b001:  return 32'h1000_1000;
            3'b010:  return 32'h2000_2000;
            3'b100:  return 32'h3000_3000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input logic [2:0] g);
        case (g)
            3'b001:  return 32'hD000_0000;
            3'b010:  return 32'hD000_0001;
            3'b100:  return 32'hD000_0002;
            default: return 32'h0;
        endcase
    endfunction

    // Full write from IDLE with an always-ready slave: ADDR, DATA, RESP, back to IDLE.
    task automatic write_txn(input logic [2:0] g_rr, input logic [2:0] g_fp, input logic [1:0] resp);
        tick();
        chk("wr_grant", wr_grant, g_rr);
        chk("s_awvalid", s_awvalid, 1);
        chk("s_awaddr", s_awaddr, addr_of(g_rr));
        chk("m_awready", m_awready, g_rr);
        chk("fp_wr_grant", f_wr_grant, g_fp);
        chk("fp_s_awaddr", f_s_awaddr, addr_of(g_fp));
        tick();
        chk("s_wvalid", s_wvalid, 1);
        chk("s_wdata", s_wdata, data_of(g_rr));
        chk("m_wready", m_wready, g_rr);
        tick();
        chk("m_bvalid", m_bvalid, g_rr);
        chk("m_bresp", m_bresp, {3{resp}});
        chk("s_bready", s_bready, 1);
        tick();
        chk("wr_grant_done", wr_grant, 0);
        chk("s_awvalid_done", s_awvalid, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        m_awaddr  = {32'h3000_3000, 32'h2000_2000, 32'h1000_1000};
        m_wdata   = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        m_araddr  = {32'h6000_6000, 32'h5000_5000, 32'h4000_4000};
        m_awprot  = 9'b010_001_000;
        m_arprot  = 9'b110_101_100;
        m_wstrb   = 12'hFFF;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        tick();
        tick();
        chk("rst_wr_grant", wr_grant, 0);
        chk("rst_rd_grant", rd_grant, 0);
        chk("rst_fp_wr_grant", f_wr_grant, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_s_arvalid", s_arvalid, 0);

        resetn    = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
        m_bready  = 3'b111;
        m_awvalid = 3'b111;
        m_wvalid  = 3'b111;
        chk("idle_s_awvalid", s_awvalid, 0);
        chk("idle_s_awaddr", s_awaddr, 0);
        chk("idle_m_bvalid", m_bvalid, 0);

        // Round-robin rotation, then wrap back to master 0.
        write_txn(3'b001, 3'b001, 2'b00);
        write_txn(3'b010, 3'b001, 2'b00);
        write_txn(3'b100, 3'b001, 2'b00);
        write_txn(3'b001, 3'b001, 2'b00);

        // Reset while stalled in the data phase.
        m_awvalid = 3'b001;
        m_wvalid  = 3'b001;
        s_wready  = 1'b0;
        tick();
        tick();
        chk("stall_s_wvalid", s_wvalid, 1);
        chk("stall_wr_grant", wr_grant, 3'b001);
        resetn = 1'b0;
        tick();
        chk("mid_rst_s_wvalid", s_wvalid, 0);
        chk("mid_rst_wr_grant", wr_grant, 0);
        chk("mid_rst_m_bvalid", m_bvalid, 0);
        chk("mid_rst_fp_wr_grant", f_wr_grant, 0);
        resetn    = 1'b1;
        s_wready  = 1'b1;

        // Lone requester 2 with pointer 0, error response.
        m_awvalid = 3'b100;
        m_wvalid  = 3'b100;
        s_bresp   = 2'b10;
        write_txn(3'b100, 3'b100, 2'b10);

        // Masters 1 and 2 competing: round-robin alternates, fixed priority keeps master 1.
        s_bresp   = 2'b00;
        m_awvalid = 3'b110;
        m_wvalid  = 3'b110;
        write_txn(3'b010, 3'b010, 2'b00);
        write_txn(3'b100, 3'b010, 2'b00);
        write_txn(3'b010, 3'b010, 2'b00);

        // Concurrent write from master 0 and read from master 1.
        m_awvalid = 3'b001;
        m_wvalid  = 3'b001;
        m_arvalid = 3'b010;
        m_rready  = 3'b010;
        tick();
        chk("cc_s_awvalid", s_awvalid, 1);
        chk("cc_s_arvalid", s_arvalid, 1);
        chk("cc_wr_grant", wr_grant, 3'b001);
        chk("cc_rd_grant", rd_grant, 3'b010);
        chk("cc_s_araddr", s_araddr, 32'h5000_5000);
        chk("cc_s_arprot", s_arprot, 3'b101);
        chk("cc_m_arready", m_arready, 3'b010);
        chk("cc_fp_rd_grant", f_rd_grant, 3'b010);
        tick();
        chk("cc_m_rvalid", m_rvalid, 3'b010);
        chk("cc_m_rdata1", m_rdata[63:32], 32'hCAFE_F00D);
        chk("cc_s_rready", s_rready, 1);
        chk("cc_s_wvalid", s_wvalid, 1);
        tick();
        chk("cc_rd_grant_done", rd_grant, 0);
        chk("cc_m_rvalid_done", m_rvalid, 0);
        chk("cc_m_bvalid", m_bvalid, 3'b001);
        m_awvalid = '0;
        m_wvalid  = '0;
        m_arvalid = '0;
        m_rready  = '0;
        tick();
        chk("end_wr_grant", wr_grant, 0);
        chk("end_rd_grant", rd_grant, 0);
        chk("end_s_arvalid", s_arvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
